// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues one imem read at a time and
// presents fetched words to decode through an output register plus a 1-entry skid.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        f_valid,
    output logic [15:0] f_instruction,
    output logic [15:0] f_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {StReq, StWait, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [15:0] out_pc2_q, out_pc2_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc2_q, skid_pc2_d;
    logic        drop_q, drop_d;

    logic        issue;
    logic        accept;
    logic        consume;
    logic        resp_live;
    logic [15:0] resp_pc2;

    // rst_n gates the request so nothing is presented to memory during reset.
    assign issue     = rst_n && (state_q == StReq) && !redirect && !skid_valid_q;
    assign accept    = issue && imem_ready;
    assign consume   = !stall && out_valid_q;
    assign resp_live = (state_q == StWait) && imem_rvalid && !drop_q;
    assign resp_pc2  = req_pc_q + 16'd2;

    assign imem_req      = issue;
    assign imem_addr     = pc_q;
    assign f_valid       = out_valid_q;
    assign f_instruction = out_instr_q;
    assign f_pc_plus2    = out_pc2_q;
    assign halted        = (state_q == StHalt);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc2_d    = out_pc2_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc2_d   = skid_pc2_q;
        drop_d       = drop_q;

        if (redirect) begin
            pc_d         = {redirect_pc[15:1], 1'b0};
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = StReq;
            // A response arriving with the redirect is simply discarded; only a
            // still-pending one needs to be dropped later.
            if ((state_q == StWait) && !imem_rvalid) begin
                drop_d = 1'b1;
            end else if (imem_rvalid) begin
                drop_d = 1'b0;
            end
        end else begin
            if (consume) begin
                out_valid_d = skid_valid_q;
                if (skid_valid_q) begin
                    out_instr_d = skid_instr_q;
                    out_pc2_d   = skid_pc2_q;
                end
                skid_valid_d = 1'b0;
            end

            if (imem_rvalid && drop_q) begin
                drop_d = 1'b0;
                if (state_q == StWait) begin
                    state_d = StReq;
                end
            end

            unique case (state_q)
                StReq: begin
                    if (accept) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 16'd2;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (resp_live) begin
                        if (!out_valid_q || consume) begin
                            out_valid_d = 1'b1;
                            out_instr_d = imem_rdata;
                            out_pc2_d   = resp_pc2;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc2_d   = resp_pc2;
                        end
                        state_d = (imem_rdata[15:12] == 4'hF) ? StHalt : StReq;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StReq;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StReq;
            pc_q         <= 16'h0000;
            req_pc_q     <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 16'h0000;
            out_pc2_q    <= 16'h0000;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 16'h0000;
            skid_pc2_q   <= 16'h0000;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc2_q    <= out_pc2_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc2_q   <= skid_pc2_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, a latency-programmable
// memory, directed scenarios with literal expectations, then a randomized run.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        f_valid;
    logic [15:0] f_instruction;
    logic [15:0] f_pc_plus2;
    logic        halted;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .f_valid      (f_valid),
        .f_instruction(f_instruction),
        .f_pc_plus2   (f_pc_plus2),
        .halted       (halted)
    );

    int checks = 0;
    int failures = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC, held words in delivery order, one outstanding request.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } entry_t;

    entry_t      held[$];
    logic [15:0] m_pc;
    logic [15:0] m_reqpc;
    bit          m_wait;
    bit          m_drop;
    bit          m_halt;

    // Memory model and directed-test controls.
    bit          busy;
    int          cnt;
    logic [15:0] maddr;
    int          lat;
    bit          bp;
    int          mode;
    bit          hlt_en;
    logic [15:0] hlt_addr;
    bit          rand_mode;
    logic        stall_r;
    logic        redir_r;
    logic [15:0] rpc_r;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
        int          cyc;
    } dlv_t;

    dlv_t        delivered[$];
    logic [15:0] accepted[$];
    int          req_count;
    int          cyc;
    logic        s_req;
    logic [15:0] s_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        if (mode == 0) begin
            w = (hlt_en && a == hlt_addr) ? 16'hF000 : 16'h1000 + a;
        end else begin
            w = (a * 16'h9E37) ^ 16'h5A3C;
        end
        return w;
    endfunction

    task automatic model_step(input bit acc);
        entry_t e;
        if (redirect) begin
            if (m_wait && !imem_rvalid) m_drop = 1'b1;
            else if (imem_rvalid) m_drop = 1'b0;
            m_pc = {redirect_pc[15:1], 1'b0};
            held.delete();
            m_wait = 1'b0;
            m_halt = 1'b0;
        end else begin
            if (!stall && held.size() > 0) void'(held.pop_front());
            if (imem_rvalid) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_wait = 1'b0;
                end else if (m_wait) begin
                    e.instr = imem_rdata;
                    e.pc2   = m_reqpc + 16'd2;
                    held.push_back(e);
                    m_wait = 1'b0;
                    if (imem_rdata[15:12] == 4'hF) m_halt = 1'b1;
                end
            end
            if (acc) begin
                m_reqpc = m_pc;
                m_pc    = m_pc + 16'd2;
                m_wait  = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        bit exp_req;
        bit acc;
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(maddr);
            end
        end
        imem_ready = !busy && (!bp || $urandom_range(3) != 0);
        if (rand_mode) begin
            stall       = $urandom_range(9) < 3;
            redirect    = $urandom_range(99) < 6;
            redirect_pc = 16'($urandom);
        end else begin
            stall       = stall_r;
            redirect    = redir_r;
            redirect_pc = rpc_r;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        exp_req = !m_wait && !m_halt && !redirect && held.size() < 2;
        check1("imem_req", imem_req, exp_req);
        if (exp_req) check16("imem_addr", imem_addr, m_pc);
        if (f_valid && !stall && !redirect) delivered.push_back('{f_instruction, f_pc_plus2, cyc});
        acc = imem_req && imem_ready;
        if (acc) begin
            accepted.push_back(imem_addr);
            req_count++;
        end
        model_step(exp_req && imem_ready);
        if (imem_rvalid) busy = 1'b0;
        if (acc) begin
            busy  = 1'b1;
            cnt   = (lat == 0) ? int'($urandom_range(3, 1)) : lat;
            maddr = imem_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        check1("f_valid", f_valid, held.size() > 0);
        if (held.size() > 0) begin
            check16("f_instruction", f_instruction, held[0].instr);
            check16("f_pc_plus2", f_pc_plus2, held[0].pc2);
        end
        check1("halted", halted, m_halt);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        stall_r = 1'b0;
        redir_r = 1'b0;
        rpc_r   = 16'h0000;
        busy = 1'b0;
        cnt  = 0;
        m_pc = 16'h0000;
        m_reqpc = 16'h0000;
        m_wait = 1'b0;
        m_drop = 1'b0;
        m_halt = 1'b0;
        held.delete();
        delivered.delete();
        accepted.delete();
        req_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_imem_req", imem_req, 1'b0);
        check1("rst_f_valid", f_valid, 1'b0);
        check16("rst_f_instruction", f_instruction, 16'h0000);
        check16("rst_f_pc_plus2", f_pc_plus2, 16'h0000);
        check1("rst_halted", halted, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rc;
        rand_mode = 1'b0;
        bp = 1'b0;
        mode = 0;
        hlt_en = 1'b0;
        hlt_addr = 16'h0006;

        // Straight line, L=1.
        lat = 1;
        do_reset();
        cycle();
        check1("t1_first_req", s_req, 1'b1);
        check16("t1_first_addr", s_addr, 16'h0000);
        repeat (8) cycle();
        check1("t1_count", delivered.size() >= 3, 1'b1);
        if (delivered.size() >= 3) begin
            check16("t1_i0", delivered[0].instr, 16'h1000);
            check16("t1_p0", delivered[0].pc2, 16'h0002);
            check16("t1_i1", delivered[1].instr, 16'h1002);
            check16("t1_p1", delivered[1].pc2, 16'h0004);
            check16("t1_i2", delivered[2].instr, 16'h1004);
            check16("t1_p2", delivered[2].pc2, 16'h0006);
            check_int("t1_cyc0", delivered[0].cyc, 2);
            check_int("t1_gap", delivered[2].cyc - delivered[1].cyc, 2);
        end

        // Stall with skid, L=3.
        lat = 3;
        do_reset();
        n = 0;
        while (!f_valid && n < 20) begin
            cycle();
            n++;
        end
        check1("t2_first_valid", f_valid, 1'b1);
        stall_r = 1'b1;
        rc = req_count;
        repeat (6) cycle();
        check_int("t2_reqs_in_stall", req_count - rc, 1);
        check1("t2_no_req_skid_full", s_req, 1'b0);
        check16("t2_hold", f_instruction, 16'h1000);
        stall_r = 1'b0;
        repeat (3) cycle();
        check1("t2_count", delivered.size() >= 2, 1'b1);
        if (delivered.size() >= 2) begin
            check16("t2_n", delivered[0].instr, 16'h1000);
            check16("t2_n1", delivered[1].instr, 16'h1002);
            check_int("t2_gap", delivered[1].cyc - delivered[0].cyc, 1);
        end

        // Redirect while waiting: late response dropped.
        lat = 3;
        do_reset();
        cycle();
        redir_r = 1'b1;
        rpc_r = 16'h0040;
        cycle();
        redir_r = 1'b0;
        cycle();
        check1("t3_req", s_req, 1'b1);
        check16("t3_addr", s_addr, 16'h0040);
        repeat (10) cycle();
        check1("t3_count", delivered.size() >= 1 && accepted.size() >= 2, 1'b1);
        if (delivered.size() >= 1 && accepted.size() >= 2) begin
            check16("t3_instr", delivered[0].instr, 16'h1040);
            check16("t3_pc2", delivered[0].pc2, 16'h0042);
            check_int("t3_cyc", delivered[0].cyc, 8);
            check16("t3_acc", accepted[1], 16'h0040);
        end

        // Redirect coincident with rvalid: no drop.
        lat = 2;
        do_reset();
        repeat (2) cycle();
        redir_r = 1'b1;
        rpc_r = 16'h0040;
        cycle();
        redir_r = 1'b0;
        repeat (6) cycle();
        check1("t3b_count", delivered.size() >= 1, 1'b1);
        if (delivered.size() >= 1) begin
            check16("t3b_instr", delivered[0].instr, 16'h1040);
            check_int("t3b_cyc", delivered[0].cyc, 6);
        end

        // HLT at 0x0006, then resume via redirect.
        lat = 1;
        hlt_en = 1'b1;
        do_reset();
        repeat (10) cycle();
        check1("t4_count", delivered.size() >= 4, 1'b1);
        if (delivered.size() >= 4) begin
            check16("t4_hlt", delivered[3].instr, 16'hF000);
            check16("t4_hlt_pc2", delivered[3].pc2, 16'h0008);
        end
        rc = req_count;
        repeat (20) cycle();
        check_int("t4_no_req", req_count - rc, 0);
        check1("t4_halted", halted, 1'b1);
        redir_r = 1'b1;
        rpc_r = 16'h0010;
        cycle();
        redir_r = 1'b0;
        check1("t4_unhalt", halted, 1'b0);
        cycle();
        check1("t4_req", s_req, 1'b1);
        check16("t4_addr", s_addr, 16'h0010);
        repeat (4) cycle();
        check1("t4_resume_count", delivered.size() >= 5, 1'b1);
        if (delivered.size() >= 5) check16("t4_resume", delivered[4].instr, 16'h1010);
        hlt_en = 1'b0;

        // Wrap at 0xFFFE.
        lat = 1;
        do_reset();
        redir_r = 1'b1;
        rpc_r = 16'hFFFE;
        cycle();
        redir_r = 1'b0;
        repeat (5) cycle();
        check1("t5_count", delivered.size() >= 1 && accepted.size() >= 2, 1'b1);
        if (delivered.size() >= 1 && accepted.size() >= 2) begin
            check16("t5_instr", delivered[0].instr, 16'h0FFE);
            check16("t5_pc2", delivered[0].pc2, 16'h0000);
            check16("t5_acc0", accepted[0], 16'hFFFE);
            check16("t5_acc1", accepted[1], 16'h0000);
        end

        // Asynchronous reset with output and skid both full.
        lat = 1;
        do_reset();
        repeat (2) cycle();
        stall_r = 1'b1;
        repeat (3) cycle();
        check1("t6_pre_valid", f_valid, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check1("t6_f_valid", f_valid, 1'b0);
        check16("t6_f_instruction", f_instruction, 16'h0000);
        check16("t6_f_pc_plus2", f_pc_plus2, 16'h0000);
        check1("t6_halted", halted, 1'b0);
        check1("t6_imem_req", imem_req, 1'b0);

        // Randomized run against the model.
        lat = 0;
        bp = 1'b1;
        mode = 1;
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) cycle();
        check1("rand_progress", delivered.size() > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front end of the 16-bit pipeline. Owns the PC, issues one instruction-memory read at a time over a request/response handshake, and delivers `f_instruction` / `f_pc_plus2` to the decode stage. It also obeys stall from the hazard logic and PC redirects from the decode stage's branch resolution. It stops fetching after an HLT opcode until it is redirected.

## Interface
- No parameters. Reset PC is fixed at 16'h0000.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept this cycle; the fetch output is held
- redirect  in  1  taken branch from decode (`branching`); overrides stall
- redirect_pc  in  16  target PC, valid when `redirect`=1
- imem_req  out  1  read request
- imem_addr  out  16  read address, equal to the current PC
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  16  instruction word
- f_valid  out  1  `f_instruction` / `f_pc_plus2` hold a live instruction
- f_instruction  out  16  fetched instruction
- f_pc_plus2  out  16  address of that instruction + 2
- halted  out  1  fetch is quiescent after HLT

## Operation
- **States:** REQ (may issue), WAIT (one request outstanding), HALT.
- **Internal storage:**
  - PC register.
  - Output register (`f_*`) plus a 1-entry skid buffer, each with a valid bit.
  - `drop` flag.
  - Per-entry PC of the fetched word, used to form `f_pc_plus2`.
- **Issue:**
  - `imem_req` = state==REQ && !redirect && !skid_valid.
  - `imem_addr` = PC.
  - Request and address stay stable until `imem_ready`.
  - On accept: remember the PC, PC <= PC+2, go to WAIT.
- **Response in WAIT** (on `imem_rvalid`):
  - If `drop` is set: discard the word, clear `drop`, go to REQ.
  - Otherwise the word goes to the output register if it is empty or is being consumed this cycle (stall=0). Else it goes to the skid buffer.
  - Next state is HALT if imem_rdata[15:12]==4'hF, otherwise REQ.
- **Consume:** any cycle with stall=0 and f_valid=1 consumes the output entry. The skid entry, if any, moves to the output register the same edge.
- **Redirect** (highest priority, any state):
  - PC <= redirect_pc.
  - Clear the output and skid valid bits.
  - If in WAIT with no `imem_rvalid` this cycle, set `drop`.
  - Next state is REQ. A redirect in HALT therefore resumes fetch.
- **Arithmetic:** PC+2 is modulo 2^16, so 16'hFFFE+2 = 16'h0000. redirect_pc[0] is ignored; PC[0] is always 0.
- `halted` = (state==HALT).

## Timing
- **Reset values (async):** PC=0000, state=REQ, f_valid=0, skid empty, drop=0, f_instruction=0000, f_pc_plus2=0000, halted=0. During reset imem_req=0.
- **First request:** imem_req=1 with addr 0000 in the first cycle after rst_n deasserts.
- **Throughput:** one outstanding request. With memory latency L≥1 cycles from accept to rvalid, steady-state throughput is 1 instruction per L+1 cycles.
- **Fetch latency:** accept at cycle t, rvalid at t+L, f_valid=1 at t+L+1.
- **Back-to-back:** the next request may be issued in the cycle after rvalid.
- **Redirect timing:**
  - Redirect in cycle t gives f_valid=0 at t+1 and imem_req=1 with addr=redirect_pc at t+1.
  - Redirect and rvalid in the same cycle: the response is discarded and `drop` is not set.
- **Stall:** outputs hold all values while stall=1. At most two words are ever held; the skid buffer never overflows.
- **Reset mid-WAIT:** state is lost and the late response is ignored. The memory must also be reset.

## Test plan
1. **Reset and straight line:** L=1, imem returns 0x1000+addr. Expect f_instruction 0x1000, 0x1002, 0x1004 with f_pc_plus2 0002, 0004, 0006 at one instruction per 2 cycles, and the first imem_addr=0000 one cycle after reset release.
2. **Stall with skid:** L=3; assert stall for 6 cycles while a response lands. The output holds word N, the skid takes N+1, and no new request issues. On release, N then N+1 are delivered on consecutive cycles with nothing lost or duplicated.
3. **Redirect in flight:** redirect to 0x0040 during WAIT. The late response is dropped, the next imem_addr is 0040, and f_pc_plus2 is 0042. Repeat with redirect coincident with rvalid: no drop, the word is discarded.
4. **HLT:** imem returns 0xF000 at 0x0006. f_instruction shows F000, then halted=1 with no further imem_req for 20 cycles. A redirect to 0x0010 clears halted and fetch resumes at 0010.
5. **Wrap:** redirect to 0xFFFE. f_pc_plus2 is 0000 and the next imem_addr is 0000.
6. **Async reset mid-stall:** drop rst_n between clock edges with f_valid=1 and skid full. All outputs go to reset values immediately, without waiting for a clock edge.
